// File: rtl/inv_sbox_layer.sv
// inv_sbox_layer: iterative inverse 4-bit S-layer over a 128-bit state, four nibbles per cycle
module inv_sbox_layer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam logic [63:0] inv_tab = 64'h3c9fe5716ba8d420;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2:0] cnt;
  logic [127:0] st;
  logic [15:0] grp, sub;
  always_comb grp = st[16*cnt +: 16];
  for (genvar g = 0; g < 4; g++) begin : g_sub
    assign sub[4*g +: 4] = inv_tab[{grp[4*g +: 4], 2'b00} +: 4];
  end
  assign in_ready  = state == IDLE;
  assign busy      = state == BUSY;
  assign out_valid = state == DONE;
  assign out_data  = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          st    <= in_data;
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          st[16*cnt +: 16] <= sub;
          cnt              <= cnt + 3'd1;
          state            <= cnt == 3'd7 ? DONE : BUSY;
        end
        DONE: state <= out_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sbox_layer.sv
// tb_inv_sbox_layer: directed and randomized checks of inv_sbox_layer against a nibble-table model
module tb_inv_sbox_layer;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] in_data = '0, out_data;
  int checks = 0, errors = 0;
  logic [3:0] inv_t [16] = '{4'h0, 4'h2, 4'h4, 4'hd, 4'h8, 4'ha, 4'hb, 4'h6,
                             4'h1, 4'h7, 4'h5, 4'he, 4'hf, 4'h9, 4'hc, 4'h3};
  logic [3:0] fwd_t [16] = '{4'h0, 4'h8, 4'h1, 4'hf, 4'h2, 4'ha, 4'h7, 4'h9,
                             4'h4, 4'hd, 4'h5, 4'h6, 4'he, 4'h3, 4'hb, 4'hc};

  inv_sbox_layer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] layer(input logic [127:0] x, input bit inverse);
    logic [127:0] r;
    for (int i = 0; i < 32; i++)
      r[4*i +: 4] = inverse ? inv_t[x[4*i +: 4]] : fwd_t[x[4*i +: 4]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] d);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_ready", in_ready, 1'b1);
    in_valid = 1;
    in_data  = d;
    step();
    in_valid = 0;
  endtask

  task automatic finish_block(input string tag, input logic [127:0] exp, input bit verbose);
    int n = 0;
    while (!out_valid && n < 20) begin
      if (verbose) chk({tag, "_busy"}, {in_ready, busy}, 2'b01);
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    if (verbose) chk({tag, "_done_flags"}, {in_ready, busy, out_valid}, 3'b001);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1;
    step();
    out_ready = 0;
    if (verbose) chk({tag, "_idle"}, {in_ready, busy, out_valid}, 3'b100);
  endtask

  initial begin
    logic [127:0] a, b, x;
    #1;
    chk("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("reset_data", out_data, '0);
    step();
    rst_n = 1;
    step();
    chk("idle_hold", {in_ready, out_valid, busy}, 3'b100);

    accept('0);
    finish_block("zero", '0, 1);
    a = 128'h0123456789ABCDEF0123456789ABCDEF;
    accept(a);
    finish_block("ramp", 128'h024D8AB6175EF9C3024D8AB6175EF9C3, 1);
    chk("ramp_model", layer(a, 1), 128'h024D8AB6175EF9C3024D8AB6175EF9C3);
    accept('1);
    finish_block("allf", {32{4'h3}}, 1);

    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    accept(a);
    for (int i = 0; i < 8 && !out_valid; i++) step();
    chk("bp_valid", out_valid, 1'b1);
    in_valid = 1;
    in_data  = b;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, layer(a, 1));
      chk("bp_flags", {in_ready, busy, out_valid}, 3'b001);
      step();
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_idle", {in_ready, busy, out_valid}, 3'b100);
    step();
    in_valid = 0;
    chk("bp_second_accept", {in_ready, busy}, 2'b01);
    finish_block("bp_second", layer(b, 1), 1);

    accept(a);
    step();
    step();
    step();
    rst_n = 0;
    #1;
    chk("rst_busy_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_busy_data", out_data, '0);
    step();
    rst_n = 1;
    step();
    chk("rst_still_idle", {in_ready, out_valid, busy}, 3'b100);
    accept('1);
    finish_block("rst_allf", {32{4'h3}}, 1);

    for (int v = 0; v < 1000; v++) begin
      x = v == 0 ? 128'hFEDCBA9876543210FEDCBA9876543210 : {$urandom, $urandom, $urandom, $urandom};
      accept(layer(x, 0));
      finish_block("roundtrip", x, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_sbox_layer.md
INV_SBOX_LAYER -- requirements
Module: inv_sbox_layer

Interface
REQ-001 The block SHALL have no parameters; the state width is fixed at 128 bits (32 nibbles).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data is presented for loading.
REQ-005 in_ready  output  1  block can accept in_data.
REQ-006 in_data  input  128  state to apply the inverse S-layer to; nibble i = bits [4i+3:4i].
REQ-007 out_valid  output  1  out_data holds a completed result.
REQ-008 out_ready  input  1  consumer accepts out_data.
REQ-009 out_data  output  128  inverse-substituted state.
REQ-010 busy  output  1  high while nibble processing is in progress.

Function
REQ-011 The block SHALL apply the inverse 4-bit S-box to every nibble of in_data independently.
REQ-012 Inverse table, input->output (hex): 0->0, 1->2, 2->4, 3->d, 4->8, 5->a, 6->b, 7->6, 8->1, 9->7, a->5, b->e, c->f, d->9, e->c, f->3.
REQ-013 The table SHALL be the exact inverse of the team's forward S-box, so forward(inverse(x)) = x for all 16 values.
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0, busy=0.
REQ-016 IDLE: in_valid=1 at a clock edge loads in_data into the internal 128-bit register, clears the 3-bit group counter to 0, and moves to BUSY.
REQ-017 BUSY: in_ready=0, out_valid=0, busy=1.
REQ-018 BUSY: each edge substitutes nibble group cnt (nibbles 4*cnt..4*cnt+3) in place and increments cnt.
REQ-019 BUSY: the edge that processes cnt=7 moves to DONE, and cnt wraps to 0.
REQ-020 Latency SHALL be exactly 8 cycles: out_valid rises on the 8th rising edge after the accepting edge.
REQ-021 DONE: out_valid=1, in_ready=0, busy=0; out_data stays stable until accepted.
REQ-022 DONE: out_ready=1 at an edge completes the output handshake and moves to IDLE.
REQ-023 The next input can be accepted no earlier than the edge after the return to IDLE, giving a minimum of 10 cycles per block.
REQ-024 in_valid SHALL be ignored in BUSY and DONE; no data is lost or overwritten, since in_ready=0 in those states.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 out_data SHALL always reflect the internal register; its value outside DONE is don't-care for consumers.
REQ-027 Unprocessed nibbles SHALL keep their loaded values while BUSY; each nibble is substituted exactly once per block.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, cnt=0, internal register 0, in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-029 Reset asserted in BUSY or DONE SHALL abandon the block with no partial result emitted; the first accept after deassertion starts a fresh block.
REQ-030 Release of rst_n is assumed synchronous to clk by the integrating level; the block adds no synchronizer.

Verification
REQ-031 Load 128'h0 -> out_data = 128'h0 exactly 8 cycles after accept; busy high for exactly those 8 cycles.
REQ-032 Load 128'h0123456789ABCDEF0123456789ABCDEF -> out_data = 128'h024D8AB6175EF9C3024D8AB6175EF9C3.
REQ-033 Load all-F -> out_data = all-3.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new data -> out_data unchanged, in_ready=0, second block accepted only after the out handshake.
REQ-035 Assert rst_n=0 at BUSY cnt=3 -> outputs immediately take reset values; a following load of all-F yields all-3 with full 8-cycle latency.
REQ-036 Round trip: random 128-bit x through the team's forward S-layer and then this block -> x, for at least 1000 vectors covering all 16 nibble values.
